// File: rtl/ro_freq_meter_if.sv
// Control/result bundle of the ring-oscillator frequency meter.
// The requester (master) starts measurements and clocks out the serial result.
interface ro_freq_meter_if #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              shift;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              ser_out;

  modport master (
    output start, gate_len, shift,
    input  busy, done, count, overflow, ser_out
  );

  modport slave (
    input  start, gate_len, shift,
    output busy, done, count, overflow, ser_out
  );
endinterface

// File: rtl/ro_freq_meter.sv
// Gated rising-edge counter for an asynchronous oscillator tap, with a
// saturating parallel result and an MSB-first serial readout register.
module ro_freq_meter #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  ro_freq_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              edge_det;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat;
  logic [CNT_W-1:0]  edge_nxt;
  logic              sat_nxt;
  logic [CNT_W:0]    ser_reg;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              busy_q;
  logic              done_q;

  // NOTE: pure data-path flops carry no reset; their contents are
  // meaningless until they have been clocked a few times anyway.
  always_ff @(posedge clk) begin
    s1 <= osc_in;
    s2 <= s1;
    s3 <= s2;
  end

  assign edge_det = s2 & ~s3;

  // NOTE: defaults first so every path assigns both outputs and no latch appears.
  always_comb begin
    edge_nxt = edge_cnt;
    sat_nxt  = sat;
    if (edge_det) begin
      if (&edge_cnt) begin
        sat_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: non-blocking assignments only, so every register sees the values
  // from before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      ser_reg    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            gate_cnt <= bus.gate_len;
            edge_cnt <= '0;
            sat      <= 1'b0;
            busy_q   <= 1'b1;
            state    <= ARM;
          end else if (bus.shift) begin
            ser_reg <= {ser_reg[CNT_W-1:0], 1'b0};
          end
        end
        ARM: begin
          // Synchronizer settles here; nothing is counted in this cycle.
          if (gate_cnt == '0) begin
            count_q    <= edge_cnt;
            overflow_q <= sat;
            ser_reg    <= {sat, edge_cnt};
            done_q     <= 1'b1;
            state      <= DONE;
          end else begin
            state <= GATE;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt - GATE_W'(1);
          edge_cnt <= edge_nxt;
          sat      <= sat_nxt;
          // The last window cycle's edge is folded into the captured result.
          if (gate_cnt == GATE_W'(1)) begin
            count_q    <= edge_nxt;
            overflow_q <= sat_nxt;
            ser_reg    <= {sat_nxt, edge_nxt};
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.ser_out  = ser_reg[CNT_W];

endmodule
